// File: rtl/eq_vector_seq_pkg.sv
// Shared types and constants for the exhaustive equivalence sequencer.
package eq_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // MISR feedback polynomial and start value (CRC-16/CCITT style)
  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] SEED = 16'hFFFF;

  // Settle counter width; covers SETTLE values 0..15
  localparam int SETTLE_W = 4;

endpackage

// File: rtl/eq_vector_seq_if.sv
// Handshake, vector and response bus between the sequencer and its environment.
interface eq_vector_seq_if #(
  parameter int N_IN  = 7,
  parameter int N_OUT = 2,
  parameter int SIG_W = 16
);
  logic             start;
  logic             abort;
  logic [N_IN-1:0]  vec_out;
  logic [N_OUT-1:0] resp_a;
  logic [N_OUT-1:0] resp_b;
  logic             busy;
  logic             done;
  logic             fail;
  logic [N_IN-1:0]  first_fail_vec;
  logic [SIG_W-1:0] signature;

  // Environment side: requests runs, supplies circuit responses
  modport master (
    output start, abort, resp_a, resp_b,
    input  vec_out, busy, done, fail, first_fail_vec, signature
  );

  // Sequencer side
  modport slave (
    input  start, abort, resp_a, resp_b,
    output vec_out, busy, done, fail, first_fail_vec, signature
  );
endinterface

// File: rtl/eq_vector_seq_misr.sv
// Multiple-input signature register compacting circuit A responses.
module eq_misr
  import eq_seq_pkg::*;
#(
  parameter int SIG_W = 16,
  parameter int N_OUT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_seed_i,
  input  logic             en_i,
  input  logic [N_OUT-1:0] data_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_q, sig_d;

  // Next signature: reseed wins over a shift/fold update
  always_comb begin
    sig_d = sig_q;
    if (load_seed_i)
      sig_d = SIG_W'(SEED);
    else if (en_i)
      sig_d = {sig_q[SIG_W-2:0], 1'b0}
            ^ (sig_q[SIG_W-1] ? SIG_W'(POLY) : '0)
            ^ SIG_W'(data_i);
  end

  // Signature register
  always_ff @(posedge clk) begin
    if (rst) sig_q <= SIG_W'(SEED);
    else     sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/eq_vector_seq.sv
// Exhaustive vector sequencer: drives all 2^N_IN vectors to two candidate
// circuits, samples after a settle window, compares A vs B and signs A.
module eq_vector_seq
  import eq_seq_pkg::*;
#(
  parameter int N_IN   = 7,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 2,
  parameter int SIG_W  = 16
) (
  input logic           clk,
  input logic           rst,
  eq_vector_seq_if.slave bus
);

  localparam logic [N_IN-1:0]     VEC_LAST = '1;
  localparam logic [SETTLE_W-1:0] CNT_LAST = (SETTLE == 0) ? '0 : SETTLE_W'(SETTLE - 1);
  // With no settle window every cycle is a sample cycle
  localparam state_e              ST_VEC   = (SETTLE == 0) ? SAMPLE : APPLY;

  state_e              state_q;
  logic [N_IN-1:0]     vec_q;
  logic [SETTLE_W-1:0] cnt_q;
  logic                busy_q;
  logic                done_q;
  logic                fail_q;
  logic [N_IN-1:0]     ffv_q;

  logic mismatch;
  logic misr_load;
  logic misr_en;

  assign mismatch  = (bus.resp_a != bus.resp_b);
  assign misr_load = (state_q == IDLE) && bus.start;
  assign misr_en   = (state_q == SAMPLE) && !bus.abort;

  // Run control: vector stepping, settle timing, compare and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      ffv_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && bus.abort) begin
        // Abandon the run; fail/first-fail keep their partial values
        state_q <= IDLE;
        vec_q   <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (bus.start) begin
            state_q <= ST_VEC;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            fail_q  <= 1'b0;
            ffv_q   <= '0;
          end
          APPLY: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= SAMPLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          SAMPLE: begin
            if (mismatch && !fail_q) begin
              fail_q <= 1'b1;
              ffv_q  <= vec_q;
            end
            if (vec_q == VEC_LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              vec_q   <= vec_q + 1'b1;
              state_q <= ST_VEC;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  eq_misr #(.SIG_W(SIG_W), .N_OUT(N_OUT)) u_misr (
    .clk        (clk),
    .rst        (rst),
    .load_seed_i(misr_load),
    .en_i       (misr_en),
    .data_i     (bus.resp_a),
    .sig_o      (bus.signature)
  );

  assign bus.vec_out        = vec_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.fail           = fail_q;
  assign bus.first_fail_vec = ffv_q;

endmodule

// File: tb/tb_eq_vector_seq.sv
// Bench for eq_vector_seq: a default 7-input instance and a 3-input
// zero-settle instance, checked against a run-level reference model.
module tb_eq_vector_seq;

  logic clk;
  logic rst;

  int n_chk = 0;
  int n_bad = 0;

  int         mode;             // 0: B==A, 1: B.O1=NOR(I0,I1), 2: B=A^flip[v]
  logic [1:0] flip [0:127];

  eq_vector_seq_if #(.N_IN(7), .N_OUT(2), .SIG_W(16)) a_if ();
  eq_vector_seq_if #(.N_IN(3), .N_OUT(2), .SIG_W(16)) s_if ();

  eq_vector_seq #(.N_IN(7), .N_OUT(2), .SETTLE(2), .SIG_W(16)) u_big (
    .clk(clk), .rst(rst), .bus(a_if)
  );
  eq_vector_seq #(.N_IN(3), .N_OUT(2), .SETTLE(0), .SIG_W(16)) u_small (
    .clk(clk), .rst(rst), .bus(s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Candidate A: O0 = OR of all inputs, O1 = NOR(I0,I1,I2)
  function automatic logic [1:0] resp_a_of(input int v);
    logic [1:0] r;
    r[0] = (v != 0);
    r[1] = ((v % 8) == 0);
    return r;
  endfunction

  function automatic logic [1:0] resp_b_of(input int v, input int m, input logic [1:0] fl);
    logic [1:0] r;
    r = resp_a_of(v);
    if (m == 1) r[1] = ((v % 4) == 0);
    else if (m == 2) r = r ^ fl;
    return r;
  endfunction

  // Circuits are purely combinational on the applied vector
  always_comb begin
    a_if.resp_a = resp_a_of(int'(a_if.vec_out));
    a_if.resp_b = resp_b_of(int'(a_if.vec_out), mode, flip[a_if.vec_out]);
    s_if.resp_a = resp_a_of(int'(s_if.vec_out));
    s_if.resp_b = resp_a_of(int'(s_if.vec_out));
  end

  // Signature after the first nsamp vectors have been sampled
  function automatic int model_sig(input int nsamp);
    int s;
    s = 'hFFFF;
    for (int v = 0; v < nsamp; v++)
      s = ((s << 1) & 'hFFFF) ^ (((s & 'h8000) != 0) ? 'h1021 : 0) ^ int'(resp_a_of(v));
    return s;
  endfunction

  function automatic int model_first_fail(input int nvec);
    for (int v = 0; v < nvec; v++)
      if (resp_a_of(v) != resp_b_of(v, mode, flip[v])) return v;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Start a run on the default instance and watch it cycle by cycle.
  // Cycle k is the interval after the k-th edge following the accept edge.
  task automatic run_big(input int abort_at, input int rst_at, input int p1, input int p2,
                         output int done_cyc, output int busy_cnt, output int done_cnt);
    done_cyc = 0; busy_cnt = 0; done_cnt = 0;
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    chk("start_vec",  32'(a_if.vec_out),   0);
    chk("start_sig",  32'(a_if.signature), 'hFFFF);
    chk("start_fail", 32'(a_if.fail),      0);
    for (int k = 1; k <= 1000; k++) begin
      if (a_if.busy) busy_cnt++;
      if (a_if.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = k;
      end
      a_if.start = (k == p1) || (k == p2);
      a_if.abort = (k == abort_at);
      rst        = (k == rst_at);
      @(negedge clk);
      if (done_cyc != 0 || k == abort_at || k == rst_at) break;
    end
    a_if.start = 1'b0;
    a_if.abort = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic check_full(input string tag, input int dc, input int bc, input int dn);
    int ff;
    chk({tag, "_done_cyc"}, 32'(dc), 385);
    chk({tag, "_busy_cnt"}, 32'(bc), 384);
    chk({tag, "_done_cnt"}, 32'(dn), 1);
    chk({tag, "_idle_busy"}, 32'(a_if.busy), 0);
    chk({tag, "_idle_done"}, 32'(a_if.done), 0);
    chk({tag, "_sig"}, 32'(a_if.signature), 32'(model_sig(128)));
    ff = model_first_fail(128);
    chk({tag, "_fail"}, 32'(a_if.fail), (ff >= 0) ? 1 : 0);
    if (ff >= 0) chk({tag, "_ffv"}, 32'(a_if.first_fail_vec), 32'(ff));
  endtask

  initial begin
    int dc, bc, dn, gap, nd;
    mode = 0;
    for (int v = 0; v < 128; v++) flip[v] = 2'b00;
    rst = 1'b1;
    a_if.start = 1'b0; a_if.abort = 1'b0;
    s_if.start = 1'b0; s_if.abort = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_vec",  32'(a_if.vec_out), 0);
    chk("rst_busy", 32'(a_if.busy), 0);
    chk("rst_done", 32'(a_if.done), 0);
    chk("rst_fail", 32'(a_if.fail), 0);
    chk("rst_ffv",  32'(a_if.first_fail_vec), 0);
    chk("rst_sig",  32'(a_if.signature), 'hFFFF);
    rst = 1'b0;
    @(negedge clk);

    // Identical circuits
    mode = 0;
    run_big(0, 0, 0, 0, dc, bc, dn);
    check_full("ident", dc, bc, dn);

    // Faulty B, start re-pulsed mid-run and during the done cycle
    mode = 1;
    run_big(0, 0, 50, 385, dc, bc, dn);
    check_full("fault", dc, bc, dn);
    chk("fault_ffv4", 32'(a_if.first_fail_vec), 4);
    // restart in the cycle right after done
    run_big(0, 0, 0, 0, dc, bc, dn);
    check_full("restart", dc, bc, dn);

    // Abort in cycle 100: vectors 0..32 have been sampled
    run_big(100, 0, 0, 0, dc, bc, dn);
    chk("abort_busy", 32'(a_if.busy), 0);
    chk("abort_vec",  32'(a_if.vec_out), 0);
    chk("abort_fail", 32'(a_if.fail), 1);
    chk("abort_sig",  32'(a_if.signature), 32'(model_sig(33)));
    nd = dn;
    repeat (6) begin
      if (a_if.done) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(nd), 0);
    chk("abort_sig_hold", 32'(a_if.signature), 32'(model_sig(33)));
    run_big(0, 0, 0, 0, dc, bc, dn);
    check_full("after_abort", dc, bc, dn);

    // Synchronous reset mid-run
    run_big(0, 200, 0, 0, dc, bc, dn);
    chk("mrst_vec",  32'(a_if.vec_out), 0);
    chk("mrst_busy", 32'(a_if.busy), 0);
    chk("mrst_done", 32'(a_if.done), 0);
    chk("mrst_fail", 32'(a_if.fail), 0);
    chk("mrst_ffv",  32'(a_if.first_fail_vec), 0);
    chk("mrst_sig",  32'(a_if.signature), 'hFFFF);
    @(negedge clk);
    run_big(0, 0, 0, 0, dc, bc, dn);
    check_full("after_rst", dc, bc, dn);

    // Zero-settle 3-input instance: one vector per cycle
    s_if.start = 1'b1;
    @(negedge clk);
    s_if.start = 1'b0;
    dc = 0; bc = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k <= 8) chk("small_vec", 32'(s_if.vec_out), 32'(k - 1));
      if (s_if.busy) bc++;
      if (s_if.done && dc == 0) dc = k;
      @(negedge clk);
      if (dc != 0) break;
    end
    chk("small_done_cyc", 32'(dc), 9);
    chk("small_busy_cnt", 32'(bc), 8);
    chk("small_sig",  32'(s_if.signature), 32'(model_sig(8)));
    chk("small_fail", 32'(s_if.fail), 0);

    // Randomised fault masks, idle gaps and ignored start pulses
    mode = 2;
    for (int t = 0; t < 4; t++) begin
      for (int v = 0; v < 128; v++)
        flip[v] = (t != 0 && $urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      gap = $urandom_range(0, 5);
      repeat (gap) @(negedge clk);
      run_big(0, 0, $urandom_range(2, 380), 0, dc, bc, dn);
      check_full("rand", dc, bc, dn);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/eq_vector_seq.md
Name: eq_vector_seq

Overview:
- Upstream stimulus/response stage for the gate-level equivalence test circuits (e.g. the 7-input OR / 3-input NOR pair).
- Drives every input vector exhaustively to two candidate circuits (A and B) in parallel, waits a settle window, then samples both output buses.
- Compares A against B and compacts A's responses into a MISR signature.
- Reports pass/fail, the first failing vector, and the signature through a start/done handshake.

Parameters:
- N_IN, 7, number of circuit inputs; vector counter width.
- N_OUT, 2, number of circuit outputs per candidate.
- SETTLE, 2, idle cycles between applying a vector and sampling; legal range 0..15.
- SIG_W, 16, MISR width; must be >= N_OUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  run request; honoured only in IDLE.
- abort  in  1  stop an active run; return to IDLE without done.
- vec_out  out  N_IN  vector driven to both circuits; bit i drives input Ii.
- resp_a  in  N_OUT  outputs of circuit A; bit j is Oj.
- resp_b  in  N_OUT  outputs of circuit B.
- busy  out  1  high from start accept until done/abort.
- done  out  1  one-cycle pulse when the final vector has been sampled.
- fail  out  1  sticky: some sampled resp_a != resp_b in this run.
- first_fail_vec  out  N_IN  vector of the first mismatch; valid when fail=1.
- signature  out  SIG_W  MISR contents; final once done pulses.

Behaviour:
- Reset: state=IDLE; vec_out=0; busy=0; done=0; fail=0; first_fail_vec=0; signature=SEED. rst has priority over start and abort.
- Cycle counting:
  - start accepted in IDLE at edge E0.
  - E0 sets busy=1, vec_out=0, fail=0, first_fail_vec=0, signature=SEED, and enters APPLY.
- APPLY/SETTLE:
  - Settle counter counts SETTLE cycles with vec_out held.
  - Then one SAMPLE cycle; resp_a/resp_b are registered at the SAMPLE edge.
  - Each vector therefore occupies exactly SETTLE+1 cycles.
- SAMPLE edge actions:
  - If resp_a != resp_b and fail=0: set fail=1 and first_fail_vec=vec_out.
  - Later mismatches do not overwrite first_fail_vec.
  - MISR update: sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended resp_a.
  - If vec_out == 2^N_IN-1: go to DONE; vec_out holds its last value.
  - Otherwise vec_out increments by 1 and the FSM returns to APPLY.
- DONE:
  - Lasts one cycle: done=1, busy=0.
  - Then IDLE; fail, first_fail_vec and signature hold until the next accepted start.
- Run length:
  - Total = 2^N_IN*(SETTLE+1) cycles after E0.
  - done is high in cycle 2^N_IN*(SETTLE+1)+1 relative to E0.
  - Default: 384 / 385.
- Overlapping requests:
  - start while busy is ignored, with no restart.
  - start in the DONE cycle is ignored.
- abort:
  - Any non-IDLE state goes to IDLE at the next edge: busy=0, no done pulse, vec_out=0.
  - fail and signature hold their partial values.
  - abort and start in the same IDLE cycle: start wins (abort is meaningless in IDLE).
- SETTLE=0: sample every cycle, one vector per cycle.
- Wrap-around: the vector counter never wraps within a run; the terminal vector ends the run.
- States: IDLE, APPLY, SAMPLE, DONE. APPLY is skipped when SETTLE=0.

Decomposition:
- Package eq_seq_pkg:
  - state enum (IDLE, APPLY, SAMPLE, DONE).
  - MISR constants POLY=16'h1021 and SEED=16'hFFFF.
  - settle-counter width constant (4).
- Sub-module eq_misr (SIG_W, N_OUT): load_seed, enable and data inputs; signature output.
- FSM, counters and compare logic live in eq_vector_seq.

Test Plan:
- Identical circuits, both or7/nor3 models, default parameters, start at cycle 0:
  - busy high for 384 cycles; done pulses at cycle 385.
  - fail=0.
  - signature equals the bench golden MISR over all 128 responses.
- Circuit B with O1 forced to NOR(I0,I1) (I2 ignored):
  - first mismatch at vec 4; fail=1; first_fail_vec=7'd4.
  - value unchanged by later mismatches.
- SETTLE=0, N_IN=3:
  - vec_out steps 0..7 on consecutive cycles.
  - done at cycle 9; exactly 8 MISR updates.
- abort asserted at cycle 100 of a default run:
  - next cycle busy=0, vec_out=0.
  - no done pulse; fail and signature hold.
  - a new start gives a full 385-cycle run.
- start re-pulsed at cycles 50 and 385 (the DONE cycle):
  - both ignored; run length unchanged.
  - start at cycle 386 clears fail and reseeds signature to 16'hFFFF.
- rst asserted mid-run at cycle 200:
  - next cycle all outputs equal reset values.
  - start two cycles later gives a normal run.
